pc_sequencer: RTL and testbench
===============================

# pc_sequencer

- Control FSM that sequences the fetch-stage PC register.
- Each cycle it selects the PC source code (sequential, jump, branch, return, hold) from the decoded instruction class, the branch zero-flag result and the instruction-memory stall.
- It drives flush and link-write (R7) strobes and waits for branch resolution.
- It sits between decode/execute and the PC register, which samples its output on the same rising edge.

## Interface
Parameters:
- BR_TIMEOUT, 4, maximum cycles waited in BR_WAIT for zero_valid (1..7)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- instr_valid  in  1  decode stage holds a valid instruction
- instr_class  in  3  decoded class: 0 ALU, 1 JMP, 2 CALL, 3 RET, 4 BEQ; 5–7 treated as ALU
- zero_valid  in  1  single-cycle pulse: BEQ comparison resolved in execute
- zero_flag  in  1  comparison result, qualified by zero_valid
- mem_stall  in  1  instruction memory not ready
- sig_pc_src  out  4  PC source code to PC register
- if_flush  out  1  squash instruction in IF/ID
- link_we  out  1  write PC+2 into R7 (CALL)
- busy  out  1  FSM not in RUN
- br_timeout  out  1  one-cycle pulse: branch resolved by timeout

## Operation
- PC source codes: pcDefault=0 (PC+2), pcImm=1 (jump target), pcSgnImm=2 (branch target), pcRET=3 (R7), pcHold=4. pcHold matches no PC-register case arm, so the PC keeps its value.
- Outputs are Mealy: combinational from state and inputs.
- States: RUN, BR_WAIT, FLUSH.
- RUN:
  - mem_stall: pcHold, stay in RUN.
  - No instr_valid: pcDefault.
  - ALU: pcDefault.
  - JMP: pcImm, if_flush=1, go FLUSH.
  - CALL: pcImm, if_flush=1, link_we=1, go FLUSH.
  - RET: pcRET, if_flush=1, go FLUSH.
  - BEQ: pcHold, load timeout counter with BR_TIMEOUT, go BR_WAIT.
- BR_WAIT:
  - zero_valid is captured into resolved/taken registers in any cycle, including stalled cycles.
  - Redirect happens on the first non-stalled cycle with a result, current (zero_valid) or captured.
  - Taken: pcSgnImm, if_flush=1, go FLUSH.
  - Not taken: pcDefault, go RUN.
  - Otherwise: pcHold; counter decrements on non-stalled cycles only.
  - Counter reaches 0 without a result: treat as not taken, pcDefault, pulse br_timeout, go RUN.
- FLUSH: one bubble cycle; instr_valid is ignored; pcDefault, go RUN. With mem_stall: pcHold, stay in FLUSH.
- mem_stall has priority over every redirect. A redirect code is never emitted while mem_stall=1.
- link_we and if_flush are asserted only in the cycle the redirect code is emitted.
- Reset (asserted at any time, including mid-BR_WAIT):
  - State → RUN; counter and captured result cleared.
  - While reset=1: sig_pc_src=pcHold; if_flush, link_we, busy, br_timeout = 0.

## Timing
- Decode-to-redirect latency: 0 cycles. The code is presented in the decode cycle and the PC changes at the next rising edge.
- BEQ latency: 1 + N cycles, where N = cycles until zero_valid (≤ BR_TIMEOUT), plus any stall cycles.
- Taken redirect penalty: 1 flush + 1 FLUSH bubble.
- zero_valid in the same cycle the counter hits 0: the real result wins and br_timeout stays 0.
- zero_valid outside BR_WAIT is ignored.

## Configuration
- PCSEQ_PERF_EN defined: two 16-bit outputs are added.
  - redirect_count: counts emitted pcImm/pcSgnImm/pcRET codes.
  - stall_count: counts cycles with mem_stall=1.
  - Both wrap at 0xFFFF→0 and are cleared by reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package: pcDefault/pcImm/pcSgnImm/pcRET/pcHold codes, instr_class codes, state encoding.
- Sub-module: pcseq_timeout, a down-counter with load, enable (non-stall) and zero flag.
- The FSM and output decode stay in pc_sequencer.

## Test plan
- Reset high mid-BR_WAIT → sig_pc_src=4, busy=0 immediately; after release, ALU instr_valid → sig_pc_src=0.
- CALL in RUN, no stall → same cycle sig_pc_src=1, if_flush=1, link_we=1; next cycle FLUSH with sig_pc_src=0 and instr_valid ignored; then RUN.
- BEQ, zero_valid=1 with zero_flag=1 two cycles later → two pcHold cycles, then sig_pc_src=2 with if_flush=1; BEQ with zero_flag=0 → sig_pc_src=0, no flush.
- BEQ, zero_valid pulses while mem_stall=1, stall lasts 3 cycles → pcHold throughout the stall; sig_pc_src=2 on the first unstalled cycle.
- BEQ, BR_TIMEOUT=4, no zero_valid → 4 pcHold cycles, then sig_pc_src=0 with br_timeout=1 for one cycle; RUN.
- PCSEQ_PERF_EN: JMP, RET and taken BEQ plus 5 stall cycles → redirect_count=3, stall_count=5; counter preloaded at 0xFFFF wraps to 0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// ============================================================================
// pc_sequencer_pkg : PC source codes, instruction classes and FSM states
// Revision: 1.0
// ============================================================================
`default_nettype none

package pc_sequencer_pkg;

    typedef enum logic [3:0] {
        pcDefault = 4'd0,
        pcImm     = 4'd1,
        pcSgnImm  = 4'd2,
        pcRET     = 4'd3,
        pcHold    = 4'd4
    } pc_src_t;

    localparam logic [2:0] c_CLS_ALU  = 3'd0;
    localparam logic [2:0] c_CLS_JMP  = 3'd1;
    localparam logic [2:0] c_CLS_CALL = 3'd2;
    localparam logic [2:0] c_CLS_RET  = 3'd3;
    localparam logic [2:0] c_CLS_BEQ  = 3'd4;

    localparam int c_TIMEOUT_W = 3;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BR_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    function automatic logic is_redirect(input pc_src_t src);
        return (src == pcImm) || (src == pcSgnImm) || (src == pcRET);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_if.sv
// ============================================================================
// pc_sequencer_if : decode/execute <-> PC sequencer signal bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pc_sequencer_if;
    logic       instr_valid;
    logic [2:0] instr_class;
    logic       zero_valid;
    logic       zero_flag;
    logic       mem_stall;
    logic [3:0] sig_pc_src;
    logic       if_flush;
    logic       link_we;
    logic       busy;
    logic       br_timeout;

    modport master (
        output instr_valid, instr_class, zero_valid, zero_flag, mem_stall,
        input  sig_pc_src, if_flush, link_we, busy, br_timeout
    );

    modport slave (
        input  instr_valid, instr_class, zero_valid, zero_flag, mem_stall,
        output sig_pc_src, if_flush, link_we, busy, br_timeout
    );
endinterface

`default_nettype wire

// File: rtl/pcseq_timeout.sv
// ============================================================================
// pcseq_timeout : loadable down-counter for branch-resolution timeout
// Revision: 1.0
// ============================================================================
`default_nettype none

module pcseq_timeout #(
    parameter int WIDTH = 3
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_value,
    input  wire logic             enable,
    output logic                  zero
);

    logic [WIDTH-1:0] r_count;

    // Flags the cycle whose decrement takes the count to zero.
    assign zero = (r_count == WIDTH'(1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (enable && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer : fetch-stage PC source FSM (Mealy outputs)
// Optional PCSEQ_PERF_EN adds redirect_count / stall_count outputs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int BR_TIMEOUT = 4
) (
    input  wire logic          clock,
    input  wire logic          reset,
    pc_sequencer_if.slave      seq
`ifdef PCSEQ_PERF_EN
    ,
    output logic [15:0]        redirect_count,
    output logic [15:0]        stall_count
`endif
);

    state_t  r_state;
    state_t  w_nxt_state;
    logic    r_resolved;
    logic    r_taken;
    pc_src_t w_pc_src;
    logic    w_flush;
    logic    w_link;
    logic    w_timeout;
    logic    w_load;
    logic    w_dec;
    logic    w_have_result;
    logic    w_taken;
    logic    w_cnt_zero;

    pcseq_timeout #(.WIDTH(c_TIMEOUT_W)) u_timeout (
        .clock      (clock),
        .reset      (reset),
        .load       (w_load),
        .load_value (c_TIMEOUT_W'(BR_TIMEOUT)),
        .enable     (w_dec),
        .zero       (w_cnt_zero)
    );

    always_comb begin
        w_nxt_state   = r_state;
        w_pc_src      = pcDefault;
        w_flush       = 1'b0;
        w_link        = 1'b0;
        w_timeout     = 1'b0;
        w_load        = 1'b0;
        w_dec         = 1'b0;
        w_have_result = seq.zero_valid | r_resolved;
        w_taken       = seq.zero_valid ? seq.zero_flag : r_taken;
        case (r_state)
            ST_RUN: begin
                if (seq.mem_stall) begin
                    w_pc_src = pcHold;
                end else if (seq.instr_valid) begin
                    case (seq.instr_class)
                        c_CLS_JMP: begin
                            w_pc_src    = pcImm;
                            w_flush     = 1'b1;
                            w_nxt_state = ST_FLUSH;
                        end
                        c_CLS_CALL: begin
                            w_pc_src    = pcImm;
                            w_flush     = 1'b1;
                            w_link      = 1'b1;
                            w_nxt_state = ST_FLUSH;
                        end
                        c_CLS_RET: begin
                            w_pc_src    = pcRET;
                            w_flush     = 1'b1;
                            w_nxt_state = ST_FLUSH;
                        end
                        c_CLS_BEQ: begin
                            w_pc_src    = pcHold;
                            w_load      = 1'b1;
                            w_nxt_state = ST_BR_WAIT;
                        end
                        default: w_pc_src = pcDefault;
                    endcase
                end
            end
            ST_BR_WAIT: begin
                if (seq.mem_stall) begin
                    w_pc_src = pcHold;
                end else if (w_have_result) begin
                    // A real result beats a timeout landing in the same cycle.
                    if (w_taken) begin
                        w_pc_src    = pcSgnImm;
                        w_flush     = 1'b1;
                        w_nxt_state = ST_FLUSH;
                    end else begin
                        w_nxt_state = ST_RUN;
                    end
                end else if (w_cnt_zero) begin
                    w_timeout   = 1'b1;
                    w_nxt_state = ST_RUN;
                end else begin
                    w_pc_src = pcHold;
                    w_dec    = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (seq.mem_stall) begin
                    w_pc_src = pcHold;
                end else begin
                    w_nxt_state = ST_RUN;
                end
            end
            default: w_nxt_state = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_resolved <= 1'b0;
            r_taken    <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            // Captured result lives only while we remain in BR_WAIT.
            if ((r_state != ST_BR_WAIT) || (w_nxt_state != ST_BR_WAIT)) begin
                r_resolved <= 1'b0;
                r_taken    <= 1'b0;
            end else if (seq.zero_valid) begin
                r_resolved <= 1'b1;
                r_taken    <= seq.zero_flag;
            end
        end
    end

    always_comb begin
        seq.sig_pc_src = reset ? pcHold : w_pc_src;
        seq.if_flush   = ~reset & w_flush;
        seq.link_we    = ~reset & w_link;
        seq.busy       = ~reset & (r_state != ST_RUN);
        seq.br_timeout = ~reset & w_timeout;
    end

`ifdef PCSEQ_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            redirect_count <= '0;
            stall_count    <= '0;
        end else begin
            if (is_redirect(w_pc_src)) begin
                redirect_count <= redirect_count + 16'd1;
            end
            if (seq.mem_stall) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// tb_pc_sequencer : scoreboard bench for pc_sequencer (BR_TIMEOUT = 4)
// Honours PCSEQ_PERF_EN for the optional counter outputs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic clock;
    logic reset;

    pc_sequencer_if bus ();

`ifdef PCSEQ_PERF_EN
    logic [15:0] redirect_count;
    logic [15:0] stall_count;
    int          exp_redirect;
    int          exp_stall;
`endif

    pc_sequencer #(.BR_TIMEOUT(4)) dut (
        .clock (clock),
        .reset (reset),
        .seq   (bus.slave)
`ifdef PCSEQ_PERF_EN
        ,
        .redirect_count (redirect_count),
        .stall_count    (stall_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      tag;
        logic [3:0] pc;
        logic       fl;
        logic       lk;
        logic       by;
        logic       to;
    } exp_t;

    exp_t q_exp[$];
    int   n_vec;
    int   n_err;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (q_exp.size() == 0) begin
            check_val("scoreboard_empty", 16'd1, 16'd0);
        end else begin
            e = q_exp.pop_front();
            check_val({e.tag, ".pc"},    16'(bus.sig_pc_src), 16'(e.pc));
            check_val({e.tag, ".flush"}, 16'(bus.if_flush),   16'(e.fl));
            check_val({e.tag, ".link"},  16'(bus.link_we),    16'(e.lk));
            check_val({e.tag, ".busy"},  16'(bus.busy),       16'(e.by));
            check_val({e.tag, ".tmo"},   16'(bus.br_timeout), 16'(e.to));
        end
    endtask

    // One cycle: drive at negedge, queue expectation, compare mid-low phase.
    task automatic step(input string tag, input logic v, input logic [2:0] cls,
                        input logic zv, input logic zf, input logic st,
                        input logic [3:0] pc, input logic fl, input logic lk,
                        input logic by, input logic to);
        exp_t e;
        @(negedge clock);
        bus.instr_valid = v;
        bus.instr_class = cls;
        bus.zero_valid  = zv;
        bus.zero_flag   = zf;
        bus.mem_stall   = st;
        e.tag = tag; e.pc = pc; e.fl = fl; e.lk = lk; e.by = by; e.to = to;
        q_exp.push_back(e);
`ifdef PCSEQ_PERF_EN
        if (reset) begin
            exp_redirect = 0;
            exp_stall    = 0;
        end else begin
            if (pc == 4'd1 || pc == 4'd2 || pc == 4'd3) exp_redirect = (exp_redirect + 1) % 65536;
            if (st) exp_stall = (exp_stall + 1) % 65536;
        end
`endif
        #2;
        compare_out();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
`ifdef PCSEQ_PERF_EN
        exp_redirect = 0;
        exp_stall    = 0;
`endif
        reset = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr_class = 3'd0;
        bus.zero_valid  = 1'b0;
        bus.zero_flag   = 1'b0;
        bus.mem_stall   = 1'b0;

        step("rst",       1, 3'd0, 0, 0, 0, 4'd4, 0, 0, 0, 0);
        @(negedge clock); reset = 1'b0;

        step("alu",       1, 3'd0, 0, 0, 0, 4'd0, 0, 0, 0, 0);
        step("cls7_alu",  1, 3'd7, 0, 0, 0, 4'd0, 0, 0, 0, 0);
        step("call",      1, 3'd2, 0, 0, 0, 4'd1, 1, 1, 0, 0);
        step("call_fl",   1, 3'd1, 0, 0, 0, 4'd0, 0, 0, 1, 0);
        step("idle",      0, 3'd1, 0, 0, 0, 4'd0, 0, 0, 0, 0);

        step("jmp",       1, 3'd1, 0, 0, 0, 4'd1, 1, 0, 0, 0);
        step("jmp_fl",    0, 3'd0, 0, 0, 0, 4'd0, 0, 0, 1, 0);
        step("ret",       1, 3'd3, 0, 0, 0, 4'd3, 1, 0, 0, 0);
        step("ret_fl_st", 0, 3'd0, 0, 0, 1, 4'd4, 0, 0, 1, 0);
        step("ret_fl",    0, 3'd0, 0, 0, 0, 4'd0, 0, 0, 1, 0);
        step("call_st",   1, 3'd2, 0, 0, 1, 4'd4, 0, 0, 0, 0);

        // BEQ taken, result two cycles after decode
        step("beq_t",     1, 3'd4, 0, 0, 0, 4'd4, 0, 0, 0, 0);
        step("beq_t_w",   0, 3'd0, 0, 0, 0, 4'd4, 0, 0, 1, 0);
        step("beq_t_res", 0, 3'd0, 1, 1, 0, 4'd2, 1, 0, 1, 0);
        step("beq_t_fl",  0, 3'd0, 0, 0, 0, 4'd0, 0, 0, 1, 0);
        step("zv_outside",0, 3'd0, 1, 1, 0, 4'd0, 0, 0, 0, 0);

        // BEQ not taken
        step("beq_n",     1, 3'd4, 0, 0, 0, 4'd4, 0, 0, 0, 0);
        step("beq_n_res", 0, 3'd0, 1, 0, 0, 4'd0, 0, 0, 1, 0);
        step("beq_n_run", 1, 3'd0, 0, 0, 0, 4'd0, 0, 0, 0, 0);

        // BEQ resolved during a 3-cycle stall
        step("beq_s",     1, 3'd4, 0, 0, 0, 4'd4, 0, 0, 0, 0);
        step("beq_s1",    0, 3'd0, 1, 1, 1, 4'd4, 0, 0, 1, 0);
        step("beq_s2",    0, 3'd0, 0, 0, 1, 4'd4, 0, 0, 1, 0);
        step("beq_s3",    0, 3'd0, 0, 0, 1, 4'd4, 0, 0, 1, 0);
        step("beq_s_res", 0, 3'd0, 0, 0, 0, 4'd2, 1, 0, 1, 0);
        step("beq_s_fl",  0, 3'd0, 0, 0, 0, 4'd0, 0, 0, 1, 0);

        // BEQ timeout
        step("beq_to",    1, 3'd4, 0, 0, 0, 4'd4, 0, 0, 0, 0);
        step("beq_to_w1", 0, 3'd0, 0, 0, 0, 4'd4, 0, 0, 1, 0);
        step("beq_to_w2", 0, 3'd0, 0, 0, 0, 4'd4, 0, 0, 1, 0);
        step("beq_to_w3", 0, 3'd0, 0, 0, 0, 4'd4, 0, 0, 1, 0);
        step("beq_to_x",  0, 3'd0, 0, 0, 0, 4'd0, 0, 0, 1, 1);
        step("beq_to_run",0, 3'd0, 0, 0, 0, 4'd0, 0, 0, 0, 0);

        // Result arrives on the expiry cycle: result wins
        step("beq_race",  1, 3'd4, 0, 0, 0, 4'd4, 0, 0, 0, 0);
        step("race_w1",   0, 3'd0, 0, 0, 0, 4'd4, 0, 0, 1, 0);
        step("race_w2",   0, 3'd0, 0, 0, 0, 4'd4, 0, 0, 1, 0);
        step("race_w3",   0, 3'd0, 0, 0, 0, 4'd4, 0, 0, 1, 0);
        step("race_res",  0, 3'd0, 1, 1, 0, 4'd2, 1, 0, 1, 0);
        step("race_fl",   0, 3'd0, 0, 0, 0, 4'd0, 0, 0, 1, 0);

        // Reset mid-BR_WAIT after a captured taken result
        step("beq_r",     1, 3'd4, 0, 0, 0, 4'd4, 0, 0, 0, 0);
        step("beq_r_cap", 0, 3'd0, 1, 1, 1, 4'd4, 0, 0, 1, 0);
        @(negedge clock); reset = 1'b1;
        #1;
        q_exp.push_back('{tag: "rst_async", pc: 4'd4, fl: 1'b0, lk: 1'b0, by: 1'b0, to: 1'b0});
        compare_out();
`ifdef PCSEQ_PERF_EN
        exp_redirect = 0;
        exp_stall    = 0;
`endif
        @(negedge clock); reset = 1'b0;
        step("post_rst",  1, 3'd0, 0, 0, 0, 4'd0, 0, 0, 0, 0);
        step("beq_clr",   1, 3'd4, 0, 0, 0, 4'd4, 0, 0, 0, 0);
        step("beq_clr_w", 0, 3'd0, 0, 0, 0, 4'd4, 0, 0, 1, 0);
        step("beq_clr_n", 0, 3'd0, 1, 0, 0, 4'd0, 0, 0, 1, 0);
        step("idle_end",  0, 3'd0, 0, 0, 0, 4'd0, 0, 0, 0, 0);

`ifdef PCSEQ_PERF_EN
        @(negedge clock);
        check_val("redirect_count", redirect_count, 16'(exp_redirect));
        check_val("stall_count",    stall_count,    16'(exp_stall));
        begin
            int n;
            n = 65535 - exp_stall;
            bus.mem_stall = 1'b1;
            for (int i = 0; i < n; i++) @(negedge clock);
            check_val("stall_ffff", stall_count, 16'hFFFF);
            @(negedge clock);
            check_val("stall_wrap", stall_count, 16'h0000);
            bus.mem_stall = 1'b0;
        end
`endif

        if (q_exp.size() != 0) check_val("scoreboard_left", 16'(q_exp.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
